// File: rtl/swd_pkg.sv
// Shared constants, FSM states and transfer payload for the SWD MEM-AP sequencer.
package swd_pkg;

  localparam int unsigned RETRY_W = 8;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_FAULT   = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_PROTO   = 2'b11;

  localparam logic [3:0] DP_IDR      = 4'h0;
  localparam logic [3:0] DP_ABORT    = 4'h0;
  localparam logic [3:0] DP_CTRLSTAT = 4'h4;
  localparam logic [3:0] DP_SELECT   = 4'h8;
  localparam logic [3:0] DP_RDBUFF   = 4'hC;
  localparam logic [3:0] AP_CSW      = 4'h0;
  localparam logic [3:0] AP_TAR      = 4'h4;
  localparam logic [3:0] AP_DRW      = 4'hC;

  localparam logic [31:0] CTRLSTAT_PWRUP = 32'h1000_0000;

  typedef enum logic [3:0] {
    ST_INIT_CTRL, ST_INIT_SEL, ST_INIT_CSW, ST_INIT_FAIL, ST_IDLE,
    ST_TAR, ST_DRW_W, ST_DRW_R, ST_RDBUFF, ST_ABORT, ST_RESP
  } state_e;

  typedef enum logic [1:0] {SUB_ENTER, SUB_REQ, SUB_WAIT} sub_e;

  typedef struct packed {
    logic        apndp;
    logic        rnw;
    logic [3:0]  a;
    logic [31:0] wdata;
  } xfer_req_t;

endpackage

// File: rtl/swd_mem_ap_seq.sv
// Sequences 32-bit memory requests into SWD DP/AP transfers via MEM-AP bank 0,
// with bring-up, TAR caching, WAIT retry and FAULT abort handling.
import swd_pkg::*;

module swd_mem_ap_seq #(
  parameter int unsigned WAIT_RETRY_MAX = 16,
  parameter logic [31:0] CSW_VALUE      = 32'h0000_0002,
  parameter logic [31:0] ABORT_VALUE    = 32'h0000_001E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  output logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic        xfer_valid,
  input  logic        xfer_ready,
  output logic        xfer_apndp,
  output logic        xfer_rnw,
  output logic [3:0]  xfer_a,
  output logic [31:0] xfer_wdata,
  input  logic        xfer_done,
  input  logic [2:0]  xfer_ack,
  input  logic        xfer_perr,
  input  logic [31:0] xfer_rdata
);

  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(WAIT_RETRY_MAX - 1);

  state_e             state_q, state_d;
  sub_e               sub_q, sub_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               tar_valid_q, tar_valid_d;
  logic [31:0]        tar_addr_q, tar_addr_d;
  logic               lat_write_q, lat_write_d;
  logic [31:0]        lat_addr_q, lat_addr_d;
  logic [31:0]        lat_wdata_q, lat_wdata_d;
  xfer_req_t          xfer_q, xfer_d, issue_req;
  logic               xfer_valid_q, xfer_valid_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_status_q, rsp_status_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               init_done_q, init_done_d;
  logic               ack_ok, ack_wait, ack_fault, is_init;

  // init_req has priority over a same-cycle request, so ready is gated by it
  assign req_ready  = (state_q == ST_IDLE) && init_done_q && !init_req;
  assign init_done  = init_done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign xfer_valid = xfer_valid_q;
  assign xfer_apndp = xfer_q.apndp;
  assign xfer_rnw   = xfer_q.rnw;
  assign xfer_a     = xfer_q.a;
  assign xfer_wdata = xfer_q.wdata;

  assign ack_ok    = (xfer_ack == ACK_OK) && !(xfer_q.rnw && xfer_perr);
  assign ack_wait  = (xfer_ack == ACK_WAIT);
  assign ack_fault = (xfer_ack == ACK_FAULT);
  assign is_init   = (state_q == ST_INIT_CTRL) || (state_q == ST_INIT_SEL) ||
                     (state_q == ST_INIT_CSW);

  // Transfer fields issued by each issue state
  always_comb begin
    issue_req = '0;
    case (state_q)
      ST_INIT_CTRL: issue_req = '{apndp: 1'b0, rnw: 1'b0, a: DP_CTRLSTAT, wdata: CTRLSTAT_PWRUP};
      ST_INIT_SEL:  issue_req = '{apndp: 1'b0, rnw: 1'b0, a: DP_SELECT,   wdata: 32'h0};
      ST_INIT_CSW:  issue_req = '{apndp: 1'b1, rnw: 1'b0, a: AP_CSW,      wdata: CSW_VALUE};
      ST_TAR:       issue_req = '{apndp: 1'b1, rnw: 1'b0, a: AP_TAR,      wdata: lat_addr_q};
      ST_DRW_W:     issue_req = '{apndp: 1'b1, rnw: 1'b0, a: AP_DRW,      wdata: lat_wdata_q};
      ST_DRW_R:     issue_req = '{apndp: 1'b1, rnw: 1'b1, a: AP_DRW,      wdata: 32'h0};
      ST_RDBUFF:    issue_req = '{apndp: 1'b0, rnw: 1'b1, a: DP_RDBUFF,   wdata: 32'h0};
      ST_ABORT:     issue_req = '{apndp: 1'b0, rnw: 1'b0, a: DP_ABORT,    wdata: ABORT_VALUE};
      default:      issue_req = '0;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    retry_d      = retry_q;
    tar_valid_d  = tar_valid_q;
    tar_addr_d   = tar_addr_q;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    xfer_d       = xfer_q;
    xfer_valid_d = xfer_valid_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = RSP_OK;
    rsp_rdata_d  = 32'h0;
    init_done_d  = init_done_q;

    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          init_done_d = 1'b0;
          tar_valid_d = 1'b0;
          state_d     = ST_INIT_CTRL;
          sub_d       = SUB_ENTER;
          retry_d     = '0;
        end else if (req_valid && req_ready) begin
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          sub_d       = SUB_ENTER;
          retry_d     = '0;
          if (tar_valid_q && (req_addr == tar_addr_q)) begin
            state_d = req_write ? ST_DRW_W : ST_DRW_R;
          end else begin
            state_d = ST_TAR;
          end
        end
      end
      ST_INIT_FAIL: begin
        if (init_req) begin
          state_d = ST_INIT_CTRL;
          sub_d   = SUB_ENTER;
          retry_d = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        case (sub_q)
          SUB_ENTER: begin
            xfer_d       = issue_req;
            xfer_valid_d = 1'b1;
            sub_d        = SUB_REQ;
          end
          SUB_REQ: begin
            if (xfer_ready) begin
              xfer_valid_d = 1'b0;
              sub_d        = SUB_WAIT;
            end
          end
          SUB_WAIT: begin
            if (xfer_done) begin
              sub_d   = SUB_ENTER;
              retry_d = '0;
              if (ack_wait && (retry_q != RETRY_LAST) && (state_q != ST_ABORT)) begin
                retry_d = retry_q + RETRY_W'(1);
              end else if (state_q == ST_ABORT) begin
                state_d      = ST_RESP;
                rsp_valid_d  = 1'b1;
                rsp_status_d = RSP_FAULT;
              end else if (is_init) begin
                if (!ack_ok) begin
                  state_d = ST_INIT_FAIL;
                end else if (state_q == ST_INIT_CTRL) begin
                  state_d = ST_INIT_SEL;
                end else if (state_q == ST_INIT_SEL) begin
                  state_d = ST_INIT_CSW;
                end else begin
                  state_d     = ST_IDLE;
                  init_done_d = 1'b1;
                end
              end else if (ack_ok) begin
                case (state_q)
                  ST_TAR: begin
                    tar_valid_d = 1'b1;
                    tar_addr_d  = lat_addr_q;
                    state_d     = lat_write_q ? ST_DRW_W : ST_DRW_R;
                  end
                  ST_DRW_R: state_d = ST_RDBUFF;
                  ST_RDBUFF: begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = xfer_rdata;
                  end
                  default: begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                  end
                endcase
              end else begin
                tar_valid_d = 1'b0;
                if (ack_fault) begin
                  state_d = ST_ABORT;
                end else begin
                  state_d      = ST_RESP;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = ack_wait ? RSP_TIMEOUT : RSP_PROTO;
                end
              end
            end
          end
          default: sub_d = SUB_ENTER;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT_CTRL;
      sub_q        <= SUB_ENTER;
      retry_q      <= '0;
      tar_valid_q  <= 1'b0;
      tar_addr_q   <= 32'h0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
      xfer_q       <= '0;
      xfer_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= RSP_OK;
      rsp_rdata_q  <= 32'h0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      retry_q      <= retry_d;
      tar_valid_q  <= tar_valid_d;
      tar_addr_q   <= tar_addr_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      xfer_q       <= xfer_d;
      xfer_valid_q <= xfer_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      init_done_q  <= init_done_d;
    end
  end

endmodule

// File: tb/tb_swd_mem_ap_seq.sv
// Scoreboard bench for swd_mem_ap_seq with a behavioural SWD engine and tiny target memory.
import swd_pkg::*;

module tb_swd_mem_ap_seq;

  logic        clk = 1'b0;
  logic        rst, init_req, init_done;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic        xfer_valid, xfer_ready, xfer_apndp, xfer_rnw;
  logic [3:0]  xfer_a;
  logic [31:0] xfer_wdata;
  logic        xfer_done, xfer_perr;
  logic [2:0]  xfer_ack;
  logic [31:0] xfer_rdata;

  always #5 clk = ~clk;

  swd_mem_ap_seq #(.WAIT_RETRY_MAX(16)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_apndp(xfer_apndp),
    .xfer_rnw(xfer_rnw), .xfer_a(xfer_a), .xfer_wdata(xfer_wdata),
    .xfer_done(xfer_done), .xfer_ack(xfer_ack), .xfer_perr(xfer_perr),
    .xfer_rdata(xfer_rdata)
  );

  typedef struct {
    logic [1:0]  status;
    logic [31:0] rdata;
  } rsp_t;

  int checks = 0;
  int errors = 0;
  rsp_t      exp_rsp_q[$];
  xfer_req_t exp_xfer_q[$];
  logic [3:0] ack_q[$];  // {perr, ack} per transfer; empty means OK

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_x(input bit ap, input bit rnw, input logic [3:0] a, input logic [31:0] d);
    xfer_req_t x;
    x.apndp = ap; x.rnw = rnw; x.a = a; x.wdata = d;
    exp_xfer_q.push_back(x);
  endtask

  task automatic exp_r(input logic [1:0] s, input logic [31:0] d);
    rsp_t r;
    r.status = s; r.rdata = d;
    exp_rsp_q.push_back(r);
  endtask

  task automatic exp_init();
    exp_x(0, 0, 4'h4, 32'h1000_0000);
    exp_x(0, 0, 4'h8, 32'h0);
    exp_x(1, 0, 4'h0, 32'h0000_0002);
  endtask

  // Engine model: target TAR/DRW memory plus DP RDBUFF posting
  logic [31:0] mem [logic [31:0]];
  logic [31:0] eng_tar, eng_posted;
  int          phase, cnt;
  xfer_req_t   cur, e;
  logic [3:0]  resp;

  initial begin
    xfer_ready = 0; xfer_done = 0; xfer_ack = 0; xfer_perr = 0; xfer_rdata = 0;
    phase = 0; cnt = 0; eng_tar = 0; eng_posted = 0;
    forever begin
      @(negedge clk);
      xfer_done = 0; xfer_ack = 0; xfer_perr = 0; xfer_rdata = 0;
      if (rst) begin
        phase = 0;
        xfer_ready = 0;
      end else begin
        case (phase)
          0: if (xfer_valid) begin
            cur.apndp = xfer_apndp; cur.rnw = xfer_rnw; cur.a = xfer_a; cur.wdata = xfer_wdata;
            if (exp_xfer_q.size() == 0) begin
              chk("xfer_unexpected", {cur.apndp, cur.rnw, cur.a}, 64'h0);
            end else begin
              e = exp_xfer_q.pop_front();
              chk("xfer_hdr", {cur.apndp, cur.rnw, cur.a}, {e.apndp, e.rnw, e.a});
              if (!e.rnw) chk("xfer_wdata", cur.wdata, e.wdata);
            end
            xfer_ready = 1;
            phase = 1;
          end
          1: begin
            chk("xfer_valid_drop", xfer_valid, 0);
            xfer_ready = 0;
            cnt = 2;
            phase = 2;
          end
          default: if (cnt > 0) cnt--;
          else begin
            resp = (ack_q.size() != 0) ? ack_q.pop_front() : 4'b0001;
            xfer_ack  = resp[2:0];
            xfer_perr = resp[3] & cur.rnw;
            if (resp == 4'b0001) begin
              if (cur.apndp && !cur.rnw && cur.a == 4'h4) eng_tar = cur.wdata;
              if (cur.apndp && !cur.rnw && cur.a == 4'hC) mem[eng_tar] = cur.wdata;
              if (cur.apndp && cur.rnw && cur.a == 4'hC)
                eng_posted = mem.exists(eng_tar) ? mem[eng_tar] : 32'h0;
            end
            if (!cur.apndp && cur.rnw && cur.a == 4'hC)
              xfer_rdata = xfer_perr ? 32'hDEAD_BEEF : eng_posted;
            xfer_done = 1;
            phase = 0;
          end
        endcase
      end
    end
  end

  // Response monitor
  rsp_t got;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("rsp_unexpected", {rsp_status, rsp_rdata}, 64'h0);
        end else begin
          got = exp_rsp_q.pop_front();
          chk("rsp_status", rsp_status, got.status);
          chk("rsp_rdata", rsp_rdata, got.rdata);
        end
      end
    end
  end

  task automatic send(input bit w, input logic [31:0] addr, input logic [31:0] data);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = addr; req_wdata = data;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_rsp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk({"rsp_timeout_", name}, 0, 1);
    repeat (2) @(negedge clk);
    chk({"xfers_drained_", name}, 64'(exp_xfer_q.size()), 0);
  endtask

  task automatic wait_init();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; break; end
    end
    chk("init_done", {63'h0, ok}, 1);
    chk("init_xfers_drained", 64'(exp_xfer_q.size()), 0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctrl"}, {xfer_valid, xfer_apndp, xfer_rnw, xfer_a, rsp_valid, rsp_status,
                          init_done, req_ready}, 0);
    chk({name, "_data"}, {xfer_wdata, rsp_rdata}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1; init_req = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    exp_init();
    rst = 0;
    wait_init();

    // Write then read back same address: read skips TAR
    exp_x(1, 0, 4'h4, 32'h3000_8000);
    exp_x(1, 0, 4'hC, 32'h1234_5678);
    exp_r(2'b00, 32'h0);
    send(1, 32'h3000_8000, 32'h1234_5678);
    wait_rsp("write");
    exp_x(1, 1, 4'hC, 32'h0);
    exp_x(0, 1, 4'hC, 32'h0);
    exp_r(2'b00, 32'h1234_5678);
    send(0, 32'h3000_8000, 32'h0);
    wait_rsp("read");

    // WAIT three times then OK: four DRW issues
    repeat (3) ack_q.push_back(4'b0010);
    repeat (4) exp_x(1, 0, 4'hC, 32'hCAFE_F00D);
    exp_r(2'b00, 32'h0);
    send(1, 32'h3000_8000, 32'hCAFE_F00D);
    wait_rsp("wait3");

    // WAIT forever: 16 issues then timeout
    repeat (16) ack_q.push_back(4'b0010);
    repeat (16) exp_x(1, 0, 4'hC, 32'h0000_0011);
    exp_r(2'b10, 32'h0);
    send(1, 32'h3000_8000, 32'h0000_0011);
    wait_rsp("wait_timeout");

    // FAULT on TAR: ABORT then status 01
    ack_q.push_back(4'b0100);
    exp_x(1, 0, 4'h4, 32'h2000_0000);
    exp_x(0, 0, 4'h0, 32'h0000_001E);
    exp_r(2'b01, 32'h0);
    send(1, 32'h2000_0000, 32'h0000_0077);
    wait_rsp("fault");

    // Same address again re-issues TAR; RDBUFF parity error gives status 11, rdata 0
    ack_q.push_back(4'b0001);
    ack_q.push_back(4'b0001);
    ack_q.push_back(4'b1001);
    exp_x(1, 0, 4'h4, 32'h2000_0000);
    exp_x(1, 1, 4'hC, 32'h0);
    exp_x(0, 1, 4'hC, 32'h0);
    exp_r(2'b11, 32'h0);
    send(0, 32'h2000_0000, 32'h0);
    wait_rsp("parity");

    // ACK 111 on TAR
    ack_q.push_back(4'b0111);
    exp_x(1, 0, 4'h4, 32'h4000_0000);
    exp_r(2'b11, 32'h0);
    send(1, 32'h4000_0000, 32'h0000_0005);
    wait_rsp("ack111");

    // Read back the last successful write; TAR cache was cleared by the errors
    exp_x(1, 0, 4'h4, 32'h3000_8000);
    exp_x(1, 1, 4'hC, 32'h0);
    exp_x(0, 1, 4'hC, 32'h0);
    exp_r(2'b00, 32'hCAFE_F00D);
    send(0, 32'h3000_8000, 32'h0);
    wait_rsp("readback");

    // Reset while waiting for xfer_done: no response, bring-up re-runs
    exp_x(1, 0, 4'h4, 32'h5000_0000);
    send(1, 32'h5000_0000, 32'h0000_0099);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (phase == 2) begin ok = 1; break; end
    end
    chk("reach_xfer_wait", {63'h0, ok}, 1);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    exp_init();
    rst = 0;
    wait_init();

    // init_req with req_valid in the same cycle: request refused, bring-up re-runs
    @(negedge clk);
    exp_init();
    init_req = 1; req_valid = 1; req_write = 0; req_addr = 32'h3000_8000;
    #1;
    chk("ready_vs_init_req", req_ready, 0);
    @(negedge clk);
    init_req = 0; req_valid = 0;
    chk("init_done_cleared", init_done, 0);
    wait_init();

    exp_x(1, 0, 4'h4, 32'h3000_8000);
    exp_x(1, 1, 4'hC, 32'h0);
    exp_x(0, 1, 4'hC, 32'h0);
    exp_r(2'b00, 32'hCAFE_F00D);
    send(0, 32'h3000_8000, 32'h0);
    wait_rsp("post_init_read");

    repeat (5) @(negedge clk);
    chk("final_rsp_queue", 64'(exp_rsp_q.size()), 0);
    chk("final_xfer_queue", 64'(exp_xfer_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
